// File: rtl/exception_ctrl.sv
// Memory-stage exception arbiter: picks the highest-priority fault in M, drives the
// CP0 update strobes in the commit cycle, and holds the handler/EPC target until fetch takes it.
module exception_ctrl #(
  parameter bit TLB_REFILL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        stallM,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic [31:0] mem_addrM,
  input  logic [11:0] exc_flagsM,
  input  logic        tlb_if_refillM,
  input  logic        tlb_if_invM,
  input  logic        eret_instM,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_ebase,
  output logic        flush_exception,
  output logic [4:0]  except_type,
  output logic [31:0] badvaddr,
  output logic        eretM,
  output logic [31:0] pc_redirect,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic        flush_pipe
);

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {IDLE, REDIRECT} state_t;

  typedef struct packed {
    logic        hit;
    logic [4:0]  code;
    logic [31:0] bva;
    logic        refill;
    logic        eret;
  } exc_t;

  state_t      state, state_nxt;
  exc_t        exc;
  logic        int_pend, int_sample, commit;
  logic        st_ie, st_exl, st_bev;
  logic [31:0] vec_base, vec_off, target;

  assign st_ie  = cp0_status[0];
  assign st_exl = cp0_status[1];
  assign st_bev = cp0_status[22];

  assign int_sample = st_ie & ~st_exl & |(cp0_cause[15:8] & cp0_status[15:8]);

  // Interrupt sample is dropped right after a commit so the handler entry
  // (which raises EXL) is not re-taken on stale state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        int_pend <= 1'b0;
    else if (commit) int_pend <= 1'b0;
    else             int_pend <= int_sample;
  end

  always_comb begin
    exc = '0;
    exc.hit = 1'b1;
    if (int_pend)                           exc.code = EXC_INT;
    else if (exc_flagsM[0])                 begin exc.code = EXC_ADEL; exc.bva = pcM; end
    else if (tlb_if_refillM | tlb_if_invM)  begin
      exc.code = EXC_TLBL; exc.bva = pcM; exc.refill = tlb_if_refillM;
    end
    else if (exc_flagsM[1])                 exc.code = EXC_RI;
    else if (exc_flagsM[2])                 exc.code = EXC_SYS;
    else if (exc_flagsM[3])                 exc.code = EXC_BP;
    else if (exc_flagsM[4])                 exc.code = EXC_OV;
    else if (exc_flagsM[5])                 begin exc.code = EXC_ADEL; exc.bva = mem_addrM; end
    else if (exc_flagsM[6] | exc_flagsM[7]) begin
      exc.code = EXC_TLBL; exc.bva = mem_addrM; exc.refill = exc_flagsM[6];
    end
    else if (exc_flagsM[8])                 begin exc.code = EXC_ADES; exc.bva = mem_addrM; end
    else if (exc_flagsM[9] | exc_flagsM[10]) begin
      exc.code = EXC_TLBS; exc.bva = mem_addrM; exc.refill = exc_flagsM[9];
    end
    else if (exc_flagsM[11])                begin exc.code = EXC_MOD; exc.bva = mem_addrM; end
    else if (eret_instM)                    exc.eret = 1'b1;
    else                                    exc.hit = 1'b0;
  end

  // Refill gets the dedicated vector only on first-level entry (EXL=0).
  assign vec_base = st_bev ? 32'hBFC0_0200 : {cp0_ebase[31:12], 12'h000};
  assign vec_off  = (exc.refill && TLB_REFILL_EN && !st_exl) ? 32'h0 : 32'h180;
  assign target   = exc.eret ? cp0_epc : vec_base + vec_off;

  assign commit = (state == IDLE) & validM & ~stallM & exc.hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    flush_exception = 1'b0;
    except_type     = 5'd0;
    badvaddr        = 32'h0;
    eretM           = 1'b0;
    case (state)
      IDLE: if (commit) begin
        state_nxt       = REDIRECT;
        flush_exception = 1'b1;
        except_type     = exc.code;
        badvaddr        = exc.bva;
        eretM           = exc.eret;
      end
      REDIRECT: if (redirect_ready && redirect_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      pc_redirect    <= 32'h0;
    end else if (commit) begin
      redirect_valid <= 1'b1;
      pc_redirect    <= target;
    end else if (state == REDIRECT && redirect_ready && redirect_valid) begin
      redirect_valid <= 1'b0;
    end
  end

  assign flush_pipe = commit | (state == REDIRECT);

  // Delay-slot status is consumed by CP0 directly; remaining CP0 bits are not needed here.
  logic unused_ok;
  assign unused_ok = ^{is_in_delayslotM, cp0_cause[31:16], cp0_cause[7:0],
                       cp0_ebase[11:0], cp0_status[31:23], cp0_status[21:16],
                       cp0_status[7:2]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: vector table for priority/target decode plus
// hand sequences for stall retry, redirect back-pressure and async reset mid-redirect.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, stallM, is_in_delayslotM, tlb_if_refillM, tlb_if_invM, eret_instM;
  logic [31:0] pcM, mem_addrM, cp0_status, cp0_cause, cp0_epc, cp0_ebase;
  logic [11:0] exc_flagsM;
  logic        flush_exception, eretM, redirect_valid, redirect_ready, flush_pipe;
  logic [4:0]  except_type;
  logic [31:0] badvaddr, pc_redirect;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.TLB_REFILL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .validM(validM), .stallM(stallM), .pcM(pcM),
    .is_in_delayslotM(is_in_delayslotM), .mem_addrM(mem_addrM), .exc_flagsM(exc_flagsM),
    .tlb_if_refillM(tlb_if_refillM), .tlb_if_invM(tlb_if_invM), .eret_instM(eret_instM),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .cp0_ebase(cp0_ebase),
    .flush_exception(flush_exception), .except_type(except_type), .badvaddr(badvaddr),
    .eretM(eretM), .pc_redirect(pc_redirect), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .flush_pipe(flush_pipe)
  );

  typedef struct {
    string       name;
    logic [31:0] status, cause, pc, mem;
    logic [11:0] flags;
    logic        tif_ref, tif_inv, eret;
    logic        exp_commit;
    logic [4:0]  exp_type;
    logic [31:0] exp_bva;
    logic        exp_eret;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, logic [31:0] status, logic [31:0] cause,
                              logic [31:0] pc, logic [31:0] mem, logic [11:0] flags,
                              logic tif_ref, logic tif_inv, logic eret, logic exp_commit,
                              logic [4:0] exp_type, logic [31:0] exp_bva, logic exp_eret,
                              logic [31:0] exp_target);
    vec_t v;
    v.name = name; v.status = status; v.cause = cause; v.pc = pc; v.mem = mem;
    v.flags = flags; v.tif_ref = tif_ref; v.tif_inv = tif_inv; v.eret = eret;
    v.exp_commit = exp_commit; v.exp_type = exp_type; v.exp_bva = exp_bva;
    v.exp_eret = exp_eret; v.exp_target = exp_target;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic quiet();
    validM = 1'b0; stallM = 1'b0; exc_flagsM = '0; tlb_if_refillM = 1'b0;
    tlb_if_invM = 1'b0; eret_instM = 1'b0; cp0_status = 32'h0; cp0_cause = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    cp0_status = v.status; cp0_cause = v.cause; pcM = v.pc; mem_addrM = v.mem;
    exc_flagsM = v.flags; tlb_if_refillM = v.tif_ref; tlb_if_invM = v.tif_inv;
    eret_instM = v.eret; validM = 1'b0;
    @(posedge clk); #1;
    validM = 1'b1;
    #1;
    chk({v.name, " flush"},  {31'h0, flush_exception}, {31'h0, v.exp_commit});
    chk({v.name, " type"},   {27'h0, except_type}, {27'h0, v.exp_type});
    chk({v.name, " bva"},    badvaddr, v.exp_bva);
    chk({v.name, " eretM"},  {31'h0, eretM}, {31'h0, v.exp_eret});
    @(posedge clk); #1;
    validM = 1'b0;
    chk({v.name, " rv"}, {31'h0, redirect_valid}, {31'h0, v.exp_commit});
    if (v.exp_commit) chk({v.name, " target"}, pc_redirect, v.exp_target);
    @(posedge clk); #1;
    chk({v.name, " rv_done"}, {31'h0, redirect_valid}, 32'h0);
  endtask

  initial begin
    //                name        status        cause         pc            mem           flags    tr   ti   er   cm   type   bva           eret target
    vecs[0]  = mk("ri_bev",     32'h0040_0000, 32'h0,       32'hBFC0_0010, 32'h0,       12'h002, 0,0,0, 1, 5'd10, 32'h0,        0, 32'hBFC0_0380);
    vecs[1]  = mk("tlbl_ref",   32'h0,         32'h0,       32'h8000_0040, 32'h0040_2004,12'h040, 0,0,0, 1, 5'd2,  32'h0040_2004,0, 32'h8000_1000);
    vecs[2]  = mk("tlbl_exl",   32'h0000_0002, 32'h0,       32'h8000_0040, 32'h0040_2004,12'h040, 0,0,0, 1, 5'd2,  32'h0040_2004,0, 32'h8000_1180);
    vecs[3]  = mk("eret_ov",    32'h0,         32'h0,       32'h8000_0050, 32'h0,       12'h010, 0,0,1, 1, 5'd12, 32'h0,        0, 32'h8000_1180);
    vecs[4]  = mk("eret",       32'h0,         32'h0,       32'h8000_0050, 32'h0,       12'h000, 0,0,1, 1, 5'd0,  32'h0,        1, 32'h8000_0120);
    vecs[5]  = mk("int",        32'h0000_8001, 32'h0000_8000,32'h8000_0060,32'h0,       12'h000, 0,0,0, 1, 5'd0,  32'h0,        0, 32'h8000_1180);
    vecs[6]  = mk("int_exl",    32'h0000_8003, 32'h0000_8000,32'h8000_0060,32'h0,       12'h000, 0,0,0, 0, 5'd0,  32'h0,        0, 32'h0);
    vecs[7]  = mk("adel_if",    32'h0,         32'h0,       32'h8000_0003, 32'h0,       12'h003, 0,0,0, 1, 5'd4,  32'h8000_0003,0, 32'h8000_1180);
    vecs[8]  = mk("tlb_if_ref", 32'h0,         32'h0,       32'h0040_0000, 32'h0,       12'h002, 1,0,0, 1, 5'd2,  32'h0040_0000,0, 32'h8000_1000);
    vecs[9]  = mk("ades_mod",   32'h0,         32'h0,       32'h8000_0070, 32'h0000_1234,12'h900, 0,0,0, 1, 5'd5,  32'h0000_1234,0, 32'h8000_1180);
    vecs[10] = mk("mod",        32'h0,         32'h0,       32'h8000_0070, 32'h0000_5678,12'h800, 0,0,0, 1, 5'd1,  32'h0000_5678,0, 32'h8000_1180);
    vecs[11] = mk("tlbs_bev",   32'h0040_0000, 32'h0,       32'h8000_0080, 32'h0000_9000,12'h200, 0,0,0, 1, 5'd3,  32'h0000_9000,0, 32'hBFC0_0200);
    vecs[12] = mk("sys_brk",    32'h0,         32'h0,       32'h8000_0090, 32'h0,       12'h00C, 0,0,0, 1, 5'd8,  32'h0,        0, 32'h8000_1180);
    vecs[13] = mk("brk_ov",     32'h0,         32'h0,       32'h8000_0090, 32'h0,       12'h018, 0,0,0, 1, 5'd9,  32'h0,        0, 32'h8000_1180);
    vecs[14] = mk("int_ri",     32'h0000_8001, 32'h0000_8000,32'h8000_00A0,32'h0,       12'h002, 0,1,0, 1, 5'd0,  32'h0,        0, 32'h8000_1180);

    rst = 1'b0; quiet(); is_in_delayslotM = 1'b0; pcM = '0; mem_addrM = '0;
    cp0_epc = 32'h8000_0120; cp0_ebase = 32'h8000_1000; redirect_ready = 1'b1;
    #3;
    chk("rst rv",    {31'h0, redirect_valid}, 32'h0);
    chk("rst pc",    pc_redirect, 32'h0);
    chk("rst fpipe", {31'h0, flush_pipe}, 32'h0);
    chk("rst flush", {31'h0, flush_exception}, 32'h0);
    #9 rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // stall retry then back-pressured redirect
    @(posedge clk); #1; quiet();
    @(posedge clk); #1;
    exc_flagsM = 12'h004; validM = 1'b1; stallM = 1'b1; redirect_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall flush", {31'h0, flush_exception}, 32'h0);
      chk("stall fpipe", {31'h0, flush_pipe}, 32'h0);
      @(posedge clk); #1;
    end
    stallM = 1'b0; #1;
    chk("unstall flush", {31'h0, flush_exception}, 32'h1);
    chk("unstall type",  {27'h0, except_type}, 32'd8);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold rv",    {31'h0, redirect_valid}, 32'h1);
      chk("hold pc",    pc_redirect, 32'h8000_1180);
      chk("hold flush", {31'h0, flush_exception}, 32'h0);
      chk("hold fpipe", {31'h0, flush_pipe}, 32'h1);
      @(posedge clk); #1;
    end
    validM = 1'b0; exc_flagsM = '0; redirect_ready = 1'b1;
    @(posedge clk); #1;
    chk("release rv", {31'h0, redirect_valid}, 32'h0);

    // async reset while redirect is pending
    cp0_status = 32'h0040_0000; exc_flagsM = 12'h002; validM = 1'b1; redirect_ready = 1'b0;
    @(posedge clk); #1;
    validM = 1'b0;
    chk("pre-rst rv", {31'h0, redirect_valid}, 32'h1);
    #2 rst = 1'b0; #1;
    chk("midrst rv",    {31'h0, redirect_valid}, 32'h0);
    chk("midrst pc",    pc_redirect, 32'h0);
    chk("midrst fpipe", {31'h0, flush_pipe}, 32'h0);
    @(posedge clk); #3 rst = 1'b1;
    redirect_ready = 1'b1; validM = 1'b1; #1;
    chk("post-rst commit", {31'h0, flush_exception}, 32'h1);
    @(posedge clk); #1; validM = 1'b0;
    chk("post-rst target", pc_redirect, 32'hBFC0_0380);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Memory-stage exception arbiter and PC-redirect sequencer for the pipelined MIPS core. It consumes the CP0 state outputs (Status, Cause, EPC, EBase) together with per-instruction fault flags in M. It drives the CP0 exception-update inputs (flush_exception, except_type, badvaddr, eretM). It holds the handler or EPC target for fetch until fetch accepts it.

## Interface
- TLB_REFILL_EN, 1: when 1, a TLB refill taken with EXL=0 vectors to offset 0x000; when 0, all exceptions use offset 0x180.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- validM  in  1  M stage holds a real instruction (not a bubble).
- stallM  in  1  M stage stalled (cache request outstanding).
- pcM  in  32  PC of the M instruction.
- is_in_delayslotM  in  1  M instruction is in a delay slot.
- mem_addrM  in  32  load/store virtual address.
- exc_flagsM  in  12  {mod, tlbs_inv, tlbs_refill, ades, tlbl_inv_d, tlbl_refill_d, adel_d, ov, brk, sys, ri, tlbl_refill_if|tlbl_inv_if encoded as bit0=adel_if}; see Operation for bit map.
- tlb_if_refillM, tlb_if_invM  in  1  instruction-fetch TLB refill / invalid.
- eret_instM  in  1  M instruction is ERET.
- cp0_status, cp0_cause, cp0_epc, cp0_ebase  in  32  CP0 state.
- flush_exception  out  1  exception or ERET commits this cycle.
- except_type  out  5  MIPS ExcCode.
- badvaddr  out  32  faulting virtual address.
- eretM  out  1  committing event is ERET.
- pc_redirect  out  32  target PC for fetch.
- redirect_valid  out  1  pc_redirect valid.
- redirect_ready  in  1  fetch accepts pc_redirect.
- flush_pipe  out  1  flush IF/ID/EX; high on commit cycle and while redirect pending.

## Operation
- exc_flagsM bit map: [0] adel_if, [1] ri, [2] sys, [3] brk, [4] ov, [5] adel_d, [6] tlbl_refill_d, [7] tlbl_inv_d, [8] ades, [9] tlbs_refill, [10] tlbs_inv, [11] mod.
- Interrupt sample register int_pend <= Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]). It is updated every cycle and cleared the cycle after any commit.
- Priority, highest first, with ExcCode:
  - int (0)
  - adel_if (4)
  - tlb_if_refill/inv (2)
  - ri (10)
  - sys (8)
  - brk (9)
  - ov (12)
  - adel_d (4)
  - tlbl_refill_d/inv_d (2)
  - ades (5)
  - tlbs_refill/inv (3)
  - mod (1)
  - ERET, only when nothing else is active.
- badvaddr:
  - pcM for adel_if or an IF TLB fault.
  - mem_addrM for data address or TLB faults.
  - 0 otherwise.
- Target address:
  - ERET: cp0_epc.
  - Otherwise base = Status.BEV ? 0xBFC00200 : {EBase[31:12], 12'h000}.
  - Offset = 0x000 if the fault is a refill, TLB_REFILL_EN=1 and Status.EXL=0; else 0x180.
  - 32-bit add, wrap ignored.
- FSM IDLE:
  - commit = validM & ~stallM & (int_pend | any flag | eret_instM).
  - On commit: flush_exception=1, eretM=eret chosen, target latched into pc_redirect, redirect_valid<=1, go to REDIRECT.
- FSM REDIRECT:
  - flush_exception is forced 0; all M inputs are ignored.
  - On redirect_ready & redirect_valid: redirect_valid<=0, go to IDLE.
- When flush_exception=0: except_type=0, badvaddr=0, eretM=0. This keeps CP0 BadVAddr, Context and EntryHi unchanged.

## Timing
- flush_exception, except_type, badvaddr and eretM are combinational in the commit cycle, so CP0 samples them together with pcM at the same edge.
- pc_redirect and redirect_valid are registered; they appear 1 cycle after commit.
- Redirect holds stable until the handshake completes. The minimum exception-to-IDLE time is 2 cycles.
- int_pend has 1-cycle latency from CP0 state changes.
- stallM high blocks commit; the exception is retried each cycle until stallM drops.
- Reset (async, rst=0): state=IDLE, int_pend=0, redirect_valid=0, pc_redirect=0, flush_pipe=0, flush_exception=0.
- Reset asserted mid-REDIRECT abandons the redirect immediately.

## Test plan
- BEV=1, EXL=0, ri at pcM=0xBFC00010, no stall -> same cycle: flush_exception=1, except_type=10, badvaddr=0. Next cycle: redirect_valid=1, pc_redirect=0xBFC00380.
- BEV=0, EBase=0x80001000, EXL=0, tlbl_refill_d with mem_addrM=0x00402004 -> except_type=2, badvaddr=0x00402004, pc_redirect=0x80001000. Same stimulus with EXL=1 -> pc_redirect=0x80001180.
- eret_instM with cp0_epc=0x80000120 plus ov asserted -> except_type=12. With ov deasserted -> eretM=1, except_type=0, pc_redirect=0x80000120.
- Interrupt: IE=1, EXL=0, IM7=1, IP7=1, then validM=1 -> except_type=0, flush_exception=1. With EXL=1 -> no commit.
- stallM=1 for 3 cycles with sys asserted -> no flush; commit on the 4th cycle. Hold redirect_ready=0 for 5 cycles -> pc_redirect stable and flush_exception stays 0 throughout.
- rst pulsed low during REDIRECT -> redirect_valid=0 asynchronously; FSM is in IDLE after release.
